// File: rtl/qe_result_fifo.sv
// qe_result_fifo: first-word-fall-through FIFO for QE_M results with drop flag/counter.
// Define QE_RES_PEAK_EN to add peak/peak_valid tracking of accepted words.
module qe_result_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_result,
   input  logic                     clear,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt
`ifdef QE_RES_PEAK_EN
   ,
   output logic [DATA_W-1:0]        peak,
   output logic                     peak_valid
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              push, pop, drop;
   assign full      = count_q == FULL_CNT;
   assign empty     = count_q == '0;
   assign out_valid = !empty;
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign pop       = out_valid & out_ready;
   assign push      = in_valid & (!full | pop);
   assign drop      = in_valid & full & !pop;
   // clear behaves like reset for pointers and flags; words offered during clear are simply ignored
   always_comb begin
      mem_d = mem_q;
      if (push && !clear) mem_d[wr_ptr_q] = in_result;
      wr_ptr_d   = clear ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d   = clear ? '0 : rd_ptr_q + AW'(pop);
      count_d    = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
      overflow_d = !clear & (overflow_q | drop);
      drop_cnt_d = clear ? '0 : drop_cnt_q + DROP_W'(drop && drop_cnt_q != '1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
`ifdef QE_RES_PEAK_EN
   logic [DATA_W-1:0] peak_q, peak_d;
   logic              peak_valid_q, peak_valid_d;
   assign peak       = peak_q;
   assign peak_valid = peak_valid_q;
   always_comb begin
      peak_d       = clear ? '0 : (push && in_result > peak_q) ? in_result : peak_q;
      peak_valid_d = !clear & (peak_valid_q | push);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         peak_q       <= '0;
         peak_valid_q <= 1'b0;
      end else begin
         peak_q       <= peak_d;
         peak_valid_q <= peak_valid_d;
      end
   end
`endif
endmodule

// File: tb/tb_qe_result_fifo.sv
// tb_qe_result_fifo: queue-model scoreboard bench for qe_result_fifo (directed + random).
module tb_qe_result_fifo;
   localparam int DEPTH = 8;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, clear = 1'b0, out_ready = 1'b0;
   logic [15:0] in_result = '0;
   logic        out_valid, full, empty, overflow;
   logic [15:0] out_data;
   logic [3:0]  count;
   logic [7:0]  drop_cnt;
`ifdef QE_RES_PEAK_EN
   logic [15:0] peak;
   logic        peak_valid;
`endif
   int checks = 0, errors = 0;
   logic [15:0] mdl[$];
   logic [15:0] exp_q[$];
   int          m_drops = 0;
   bit          m_ovf = 0, m_pv = 0;
   logic [15:0] m_peak = '0;

   qe_result_fifo dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result), .clear(clear),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .count(count),
      .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef QE_RES_PEAK_EN
      , .peak(peak), .peak_valid(peak_valid)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every handshake the DUT presents must match the next expected word.
   always @(negedge clk) begin
      if (!reset && !clear && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop actual=%0d required=none", out_data);
         end else begin
            check("pop_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic check_state(input string tag);
      check({tag, "_count"}, {28'd0, count}, mdl.size());
      check({tag, "_full"}, {31'd0, full}, {31'd0, mdl.size() == DEPTH});
      check({tag, "_empty"}, {31'd0, empty}, {31'd0, mdl.size() == 0});
      check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, mdl.size() != 0});
      check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
      check({tag, "_drops"}, {24'd0, drop_cnt}, m_drops);
`ifdef QE_RES_PEAK_EN
      check({tag, "_peak"}, {16'd0, peak}, {16'd0, m_peak});
      check({tag, "_peakv"}, {31'd0, peak_valid}, {31'd0, m_pv});
`endif
   endtask

   task automatic step(input logic iv, input logic [15:0] d, input logic rdy, input logic clr, input string tag);
      bit pop_m, push_m;
      in_valid = iv; in_result = d; out_ready = rdy; clear = clr;
      if (clr) begin
         mdl.delete(); m_ovf = 0; m_drops = 0; m_peak = '0; m_pv = 0;
      end else begin
         pop_m  = mdl.size() > 0 && rdy;
         push_m = iv && (mdl.size() < DEPTH || pop_m);
         if (pop_m) exp_q.push_back(mdl.pop_front());
         if (push_m) begin
            mdl.push_back(d);
            if (d > m_peak) m_peak = d;
            m_pv = 1;
         end else if (iv) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
         end
      end
      @(posedge clk); #1;
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1; in_valid = 1; in_result = 16'($urandom); out_ready = 1; clear = 0;
      mdl.delete(); m_ovf = 0; m_drops = 0; m_peak = '0; m_pv = 0;
      @(posedge clk); #1;
      reset = 0; in_valid = 0;
      check_state(tag);
      check({tag, "_data"}, {16'd0, out_data}, 32'd0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 4 * DEPTH && mdl.size() > 0; i++) step(0, '0, 1, 0, tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] t1 [3];
      t1[0] = 16'd6465; t1[1] = 16'd3; t1[2] = 16'd802;
      repeat (2) @(posedge clk);
      #1;
      do_reset("rst");
      for (int i = 0; i < 3; i++) step(1, t1[i], 0, 0, "t1_push");
      check("t1_count3", {28'd0, count}, 32'd3);
      check("t1_head", {16'd0, out_data}, 32'd6465);
      drain("t1_drain");
      check("t1_empty", {31'd0, empty}, 32'd1);
      for (int i = 1; i <= 10; i++) step(1, 16'(i), 0, 0, "t2_push");
      check("t2_full", {31'd0, full}, 32'd1);
      check("t2_drop2", {24'd0, drop_cnt}, 32'd2);
      drain("t2_drain");
      for (int i = 1; i <= 8; i++) step(1, 16'(i + 20), 0, 0, "t3_fill");
      step(1, 16'd99, 1, 0, "t3_both");
      check("t3_count8", {28'd0, count}, 32'd8);
      drain("t3_drain");
      for (int i = 0; i < 8; i++) step(1, 16'(i), 0, 0, "t4_fill");
      for (int i = 0; i < 300; i++) step(1, 16'($urandom), 0, 0, "t4_drop");
      check("t4_sat", {24'd0, drop_cnt}, 32'd255);
      check("t4_ovf", {31'd0, overflow}, 32'd1);
      step(1, 16'd7, 0, 1, "t5_clr0");
      for (int i = 0; i < 5; i++) step(1, 16'(i + 100), 0, 0, "t5_fill");
      step(1, 16'd555, 1, 1, "t5_clear");
      check("t5_cnt0", {28'd0, count}, 32'd0);
      for (int i = 0; i < 5; i++) step(1, 16'(i + 200), 0, 0, "t5_refill");
      do_reset("t5_rst");
      step(1, 16'd800, 0, 0, "t6_push");
      step(1, 16'd51265, 0, 0, "t6_push");
      step(1, 16'd3, 0, 0, "t6_push");
`ifdef QE_RES_PEAK_EN
      check("t6_peak", {16'd0, peak}, 32'd51265);
`endif
      step(0, '0, 0, 1, "t6_clear");
      for (int p = 0; p < 4; p++) begin
         int rdy_pct;
         rdy_pct = (p == 0) ? 20 : (p == 1) ? 50 : (p == 2) ? 85 : 55;
         for (int i = 0; i < 500; i++)
            step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < rdy_pct,
                 $urandom_range(0, 63) == 0, "rnd");
         if (p == 1) do_reset("rnd_rst");
      end
      drain("final_drain");
      check("exp_left", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
